// File: rtl/eco32f_pipe_ctrl.sv
// eco32f_pipe_ctrl: stall/flush sequencer for the 5-stage eco32f pipeline.
// Merges bus waits, load-use bubbles, taken branches and MEM exceptions into
// per-stage stall/flush strobes and sequences the iterative divider.
// Optional feature: define ECO32F_PIPE_CTRL_PERF_EN to build the saturating
// performance counters; otherwise both counter ports are tied to zero.
module eco32f_pipe_ctrl #(
    parameter int DIV_CYCLES       = 32,
    parameter int EXC_FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_busy,
    input  logic                 mem_busy,
    input  logic                 id_bubble,
    input  logic                 ex_op_div,
    input  logic                 ex_op_rem,
    input  logic                 ex_branch_taken,
    input  logic                 mem_exc,
    output logic                 if_stall,
    output logic                 id_stall,
    output logic                 ex_stall,
    output logic                 mem_stall,
    output logic                 if_flush,
    output logic                 id_flush,
    output logic                 ex_flush,
    output logic                 mem_flush,
    output logic                 div_start,
    output logic                 div_done,
    output logic                 div_abort,
    output logic                 exc_redirect,
    output logic [1:0]           ctrl_state,
    output logic [CNT_WIDTH-1:0] perf_stall_cnt,
    output logic [CNT_WIDTH-1:0] perf_flush_cnt
);

    localparam int DW = $clog2(DIV_CYCLES + 1);
    localparam int EW = (EXC_FLUSH_CYCLES > 0) ? $clog2(EXC_FLUSH_CYCLES + 1) : 1;
    // The start cycle counts as the first divider cycle, so the register holds
    // the cycles still to go after the current one; done fires when it reads 0.
    localparam int DIV_LOAD = (DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_DIV = 2'd1,
        S_EXC = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt, div_cnt_nxt;
    logic [EW-1:0] exc_cnt, exc_cnt_nxt;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_RUN;
            div_cnt <= '0;
            exc_cnt <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            exc_cnt <= exc_cnt_nxt;
        end
    end

    // Next-state and all stall/flush/pulse outputs.
    always_comb begin
        state_nxt    = state;
        div_cnt_nxt  = div_cnt;
        exc_cnt_nxt  = exc_cnt;
        if_stall     = 1'b0;
        id_stall     = 1'b0;
        ex_stall     = 1'b0;
        mem_stall    = 1'b0;
        if_flush     = 1'b0;
        id_flush     = 1'b0;
        ex_flush     = 1'b0;
        mem_flush    = 1'b0;
        div_start    = 1'b0;
        div_done     = 1'b0;
        div_abort    = 1'b0;
        exc_redirect = 1'b0;
        if (rst) begin
            {if_flush, id_flush, ex_flush, mem_flush} = '1;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_busy) begin
                        {if_stall, id_stall, ex_stall, mem_stall} = '1;
                    end else if (mem_exc) begin
                        {if_flush, id_flush, ex_flush, mem_flush} = '1;
                        exc_redirect = 1'b1;
                        if (EXC_FLUSH_CYCLES > 0) begin
                            state_nxt   = S_EXC;
                            exc_cnt_nxt = EW'(EXC_FLUSH_CYCLES);
                        end
                    end else if (ex_op_div || ex_op_rem) begin
                        div_start = 1'b1;
                        if (DIV_CYCLES == 1) begin
                            div_done = 1'b1;
                        end else begin
                            {if_stall, id_stall, ex_stall} = '1;
                            mem_flush   = 1'b1;
                            state_nxt   = S_DIV;
                            div_cnt_nxt = DW'(DIV_LOAD);
                        end
                    end else if (ex_branch_taken) begin
                        if_flush = 1'b1;
                        id_flush = 1'b1;
                    end else if (id_bubble) begin
                        if_stall = 1'b1;
                    end else if (if_busy) begin
                        id_flush = 1'b1;
                    end
                end
                S_DIV: begin
                    if (div_cnt != '0) begin
                        div_cnt_nxt = div_cnt - DW'(1);
                    end
                    if (mem_exc && !mem_busy) begin
                        div_abort    = 1'b1;
                        exc_redirect = 1'b1;
                        {if_flush, id_flush, ex_flush, mem_flush} = '1;
                        div_cnt_nxt  = '0;
                        if (EXC_FLUSH_CYCLES > 0) begin
                            state_nxt   = S_EXC;
                            exc_cnt_nxt = EW'(EXC_FLUSH_CYCLES);
                        end else begin
                            state_nxt   = S_RUN;
                        end
                    end else if (div_cnt == '0 && !mem_busy) begin
                        div_done  = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        {if_stall, id_stall, ex_stall} = '1;
                        mem_stall = mem_busy;
                        mem_flush = !mem_busy;
                    end
                end
                S_EXC: begin
                    {if_flush, id_flush, ex_flush, mem_flush} = '1;
                    if (exc_cnt != '0) begin
                        exc_cnt_nxt = exc_cnt - EW'(1);
                    end
                    if (exc_cnt <= EW'(1)) begin
                        state_nxt = S_RUN;
                    end
                end
                default: begin
                    state_nxt = S_RUN;
                end
            endcase
        end
    end

    assign ctrl_state = state;

`ifdef ECO32F_PIPE_CTRL_PERF_EN
    // In RUN, a front-end flush without ex_flush only comes from a taken branch.
    logic flush_evt;
    assign flush_evt = exc_redirect || (state == S_RUN && if_flush && !ex_flush);

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (if_stall && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_WIDTH'(1);
            end
            if (flush_evt && perf_flush_cnt != '1) begin
                perf_flush_cnt <= perf_flush_cnt + CNT_WIDTH'(1);
            end
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_eco32f_pipe_ctrl.sv
// Testbench for eco32f_pipe_ctrl: directed vector table for RUN-state
// priority decoding, plus hand-written divider/exception/reset sequences.
module tb_eco32f_pipe_ctrl;

    localparam int CW = 4;

    // Input bundle: {if_busy, mem_busy, id_bubble, ex_op_div, ex_op_rem, ex_branch_taken, mem_exc}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_IFB  = 7'b1000000;
    localparam logic [6:0] I_MB   = 7'b0100000;
    localparam logic [6:0] I_BUB  = 7'b0010000;
    localparam logic [6:0] I_DIV  = 7'b0001000;
    localparam logic [6:0] I_REM  = 7'b0000100;
    localparam logic [6:0] I_BR   = 7'b0000010;
    localparam logic [6:0] I_EXC  = 7'b0000001;

    // Output bundle: {if/id/ex/mem_stall, if/id/ex/mem_flush, div_start, div_done,
    //                 div_abort, exc_redirect, ctrl_state[1:0]}
    localparam logic [13:0] E_IDLE  = 14'b0000_0000_0000_00;
    localparam logic [13:0] E_MB    = 14'b1111_0000_0000_00;
    localparam logic [13:0] E_BR    = 14'b0000_1100_0000_00;
    localparam logic [13:0] E_BUB   = 14'b1000_0000_0000_00;
    localparam logic [13:0] E_IFB   = 14'b0000_0100_0000_00;
    localparam logic [13:0] E_START = 14'b1110_0001_1000_00;
    localparam logic [13:0] E_DIVW  = 14'b1110_0001_0000_01;
    localparam logic [13:0] E_DIVB  = 14'b1111_0000_0000_01;
    localparam logic [13:0] E_DONE  = 14'b0000_0000_0100_01;
    localparam logic [13:0] E_ABORT = 14'b0000_1111_0011_01;
    localparam logic [13:0] E_REDIR = 14'b0000_1111_0001_00;
    localparam logic [13:0] E_EXC   = 14'b0000_1111_0000_10;
    localparam logic [13:0] E_RST   = 14'b0000_1111_0000_00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic if_busy, mem_busy, id_bubble, ex_op_div, ex_op_rem, ex_branch_taken, mem_exc;
    logic if_stall, id_stall, ex_stall, mem_stall;
    logic if_flush, id_flush, ex_flush, mem_flush;
    logic div_start, div_done, div_abort, exc_redirect;
    logic [1:0]    ctrl_state;
    logic [CW-1:0] perf_stall_cnt, perf_flush_cnt;
    logic [13:0]   obs;

    int passed = 0;
    int total  = 0;

    eco32f_pipe_ctrl #(
        .DIV_CYCLES      (4),
        .EXC_FLUSH_CYCLES(2),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_busy        (if_busy),
        .mem_busy       (mem_busy),
        .id_bubble      (id_bubble),
        .ex_op_div      (ex_op_div),
        .ex_op_rem      (ex_op_rem),
        .ex_branch_taken(ex_branch_taken),
        .mem_exc        (mem_exc),
        .if_stall       (if_stall),
        .id_stall       (id_stall),
        .ex_stall       (ex_stall),
        .mem_stall      (mem_stall),
        .if_flush       (if_flush),
        .id_flush       (id_flush),
        .ex_flush       (ex_flush),
        .mem_flush      (mem_flush),
        .div_start      (div_start),
        .div_done       (div_done),
        .div_abort      (div_abort),
        .exc_redirect   (exc_redirect),
        .ctrl_state     (ctrl_state),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {if_stall, id_stall, ex_stall, mem_stall,
                  if_flush, id_flush, ex_flush, mem_flush,
                  div_start, div_done, div_abort, exc_redirect, ctrl_state};

    typedef struct {
        logic [6:0]  in;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    task automatic set_in(input logic [6:0] v);
        {if_busy, mem_busy, id_bubble, ex_op_div, ex_op_rem, ex_branch_taken, mem_exc} = v;
    endtask

    // Advance to the next cycle, apply inputs just after the edge, sample at negedge.
    task automatic go(input logic [6:0] v);
        @(posedge clk);
        #1;
        set_in(v);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(I_NONE);
        @(negedge clk);
        chk("rst_outputs", 32'(obs), 32'(E_RST));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [13:0] exp_a[5];
        logic [13:0] exp_c[7];
        logic [6:0]  in_c[7];

        vecs[0] = '{I_NONE, E_IDLE};
        vecs[1] = '{I_MB, E_MB};
        vecs[2] = '{I_BR, E_BR};
        vecs[3] = '{I_BUB, E_BUB};
        vecs[4] = '{I_IFB, E_IFB};
        vecs[5] = '{I_BR | I_BUB | I_IFB, E_BR};
        vecs[6] = '{I_BUB | I_IFB, E_BUB};
        vecs[7] = '{I_MB | I_EXC, E_MB};
        vecs[8] = '{I_MB | I_DIV | I_BR, E_MB};

        // Reset state
        set_in(I_NONE);
        @(negedge clk);
        chk("rst_outputs", 32'(obs), 32'(E_RST));
        chk("rst_perf_stall", 32'(perf_stall_cnt), 32'd0);
        chk("rst_perf_flush", 32'(perf_flush_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // RUN-state priority table
        for (int i = 0; i < 9; i++) begin
            go(vecs[i].in);
            chk($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
        end

        // Division, no interruptions
        exp_a = '{E_START, E_DIVW, E_DIVW, E_DONE, E_IDLE};
        for (int c = 0; c < 5; c++) begin
            go(c == 0 ? I_DIV : I_NONE);
            chk($sformatf("div_t%0d", c), 32'(obs), 32'(exp_a[c]));
        end

        // Division aborted by an exception at t2
        go(I_DIV);   chk("abort_t0", 32'(obs), 32'(E_START));
        go(I_NONE);  chk("abort_t1", 32'(obs), 32'(E_DIVW));
        go(I_EXC);   chk("abort_t2", 32'(obs), 32'(E_ABORT));
        go(I_NONE);  chk("abort_t3", 32'(obs), 32'(E_EXC));
        go(I_IFB | I_DIV | I_BR); chk("abort_t4", 32'(obs), 32'(E_EXC));
        go(I_NONE);  chk("abort_t5", 32'(obs), 32'(E_IDLE));

        // Remainder held at count 0 by mem_busy for two cycles
        in_c  = '{I_REM, I_NONE, I_NONE, I_MB, I_MB, I_NONE, I_NONE};
        exp_c = '{E_START, E_DIVW, E_DIVW, E_DIVB, E_DIVB, E_DONE, E_IDLE};
        for (int c = 0; c < 7; c++) begin
            go(in_c[c]);
            chk($sformatf("busy_t%0d", c), 32'(obs), 32'(exp_c[c]));
        end

        // mem_busy masks mem_exc; redirect follows once the bus is free
        go(I_MB | I_EXC); chk("mbexc_t0", 32'(obs), 32'(E_MB));
        go(I_EXC);        chk("mbexc_t1", 32'(obs), 32'(E_REDIR));
        go(I_NONE);       chk("mbexc_t2", 32'(obs), 32'(E_EXC));
        go(I_NONE);       chk("mbexc_t3", 32'(obs), 32'(E_EXC));
        go(I_NONE);       chk("mbexc_t4", 32'(obs), 32'(E_IDLE));

        // Reset mid-division returns to RUN without an abort pulse
        go(I_DIV);  chk("rstdiv_t0", 32'(obs), 32'(E_START));
        go(I_NONE); chk("rstdiv_t1", 32'(obs), 32'(E_DIVW));
        #1;
        rst = 1'b1;
        #1;
        chk("rstdiv_async", 32'(obs), 32'(E_RST));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstdiv_run", 32'(obs), 32'(E_IDLE));

        // Performance counters: one branch, then 20 load-use bubbles
        do_reset();
        set_in(I_BR);
        for (int c = 0; c < 20; c++) go(I_BUB);
        go(I_NONE);
`ifdef ECO32F_PIPE_CTRL_PERF_EN
        chk("perf_stall_sat", 32'(perf_stall_cnt), 32'd15);
        chk("perf_flush_one", 32'(perf_flush_cnt), 32'd1);
        go(I_NONE);
        chk("perf_stall_hold", 32'(perf_stall_cnt), 32'd15);
`else
        chk("perf_stall_tied", 32'(perf_stall_cnt), 32'd0);
        chk("perf_flush_tied", 32'(perf_flush_cnt), 32'd0);
        go(I_NONE);
        chk("perf_stall_hold", 32'(perf_stall_cnt), 32'd0);
`endif
        do_reset();
        @(negedge clk);
        chk("perf_stall_clr", 32'(perf_stall_cnt), 32'd0);
        chk("perf_flush_clr", 32'(perf_flush_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, passed %0d of %0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
